// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory access path.
//   MODE_*   : MemMode encodings driven by the controller.
//   state_t  : mem_access_unit state encoding.
//   mem_req_t: fields latched from an accepted request.
package mips_mem_pkg;

  localparam logic [1:0] MODE_WORD  = 2'b00;
  localparam logic [1:0] MODE_SBYTE = 2'b01;
  localparam logic [1:0] MODE_UBYTE = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_DONE,
    ST_ERR
  } state_t;

  // Only what is needed after IDLE: the word address goes straight to
  // ram_addr, and word-store data straight to ram_wdata.
  typedef struct packed {
    logic       we;
    logic [1:0] mode;
    logic [1:0] lane;
    logic [7:0] wbyte;
  } mem_req_t;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane logic for sub-word accesses (little-endian lanes).
//   word      : word read from RAM
//   sel       : byte lane (addr[1:0])
//   mode      : MemMode; selects word / sign-extend / zero-extend result
//   wbyte     : store byte for read-modify-write
//   load_data : extended load result
//   merged    : word with lane 'sel' replaced by wbyte
module byte_lane_unit
  import mips_mem_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0][7:0]       word,
  input  logic [$clog2(NUM_LANES)-1:0]    sel,
  input  logic [1:0]                      mode,
  input  logic [7:0]                      wbyte,
  output logic [NUM_LANES*8-1:0]          load_data,
  output logic [NUM_LANES-1:0][7:0]       merged
);

  localparam int W = NUM_LANES * 8;

  logic [7:0] lane_b;
  assign lane_b = word[sel];

  always_comb begin
    load_data = W'(lane_b);
    case (mode)
      MODE_WORD:  load_data = word;
      MODE_SBYTE: load_data = {{(W-8){lane_b[7]}}, lane_b};
      default:    load_data = W'(lane_b);
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[i] = (int'(sel) == i) ? wbyte : word[i];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store unit between the MIPS core and a word-wide
// synchronous RAM without byte enables. Byte stores are done as
// read-modify-write.
//   clk, reset        : clock, synchronous active-low reset
//   req, we, mode     : request strobe, store flag, MemMode (sampled in IDLE)
//   addr, wdata       : byte address, store data
//   rdata             : last load result (held between loads)
//   busy, done, err   : in progress, completion pulse, error flag (with done)
//   ram_en/we/addr/wdata, ram_rdata : RAM port; rdata valid WAIT_CYCLES
//                       cycles after the read-enable cycle
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        mode,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  state_t     state;
  mem_req_t   r;
  logic [CNT_W-1:0] cnt;
  logic [31:0] ld_data;
  logic [31:0] mg_data;

  // Operates directly on ram_rdata; results are registered on the capture
  // cycle, so nothing here reaches an output combinationally.
  byte_lane_unit #(.NUM_LANES(4)) u_lane (
    .word      (ram_rdata),
    .sel       (r.lane),
    .mode      (r.mode),
    .wbyte     (r.wbyte),
    .load_data (ld_data),
    .merged    (mg_data)
  );

  assign busy = (state != ST_IDLE);

  // RAM strobes and done/err are registered for the state being entered,
  // so each is high exactly during the matching state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      r         <= '0;
      cnt       <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            r.we     <= we;
            r.mode   <= mode;
            r.lane   <= addr[1:0];
            r.wbyte  <= wdata[7:0];
            ram_addr <= addr[ADDR_W+1:2];
            if (mode == MODE_RSVD || (mode == MODE_WORD && addr[1:0] != 2'b00)) begin
              state <= ST_ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (we && mode == MODE_WORD) begin
              state     <= ST_WR;
              ram_en    <= 1'b1;
              ram_we    <= 1'b1;
              ram_wdata <= wdata;
            end else begin
              // loads and byte-store read phase
              state  <= ST_RD;
              ram_en <= 1'b1;
              ram_we <= 1'b0;
            end
          end
        end
        ST_RD: begin
          ram_en <= 1'b0;
          cnt    <= CNT_W'(WAIT_CYCLES);
          state  <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          cnt <= cnt - 1'b1;
          // cnt==1 marks the cycle ram_rdata is valid
          if (cnt == CNT_W'(1)) begin
            if (r.we) begin
              ram_wdata <= mg_data;
              ram_en    <= 1'b1;
              ram_we    <= 1'b1;
              state     <= ST_WR;
            end else begin
              rdata <= ld_data;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_WR: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE, ST_ERR: state <= ST_IDLE;
        default:         state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  typedef struct {
    int          cyc;
    logic        we;
    logic [29:0] a;
    logic [31:0] d;
  } acc_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  mode;
  logic [31:0] addr, wdata;
  logic        req_w[2];
  logic [31:0] rdata_w[2], ram_wdata_w[2], ram_rdata_w[2];
  logic        busy_w[2], done_w[2], err_w[2], ram_en_w[2], ram_we_w[2];
  logic [29:0] ram_addr_w[2];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  acc_exp_t  aq[2][$];
  done_exp_t dq[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit #(.ADDR_W(30), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_w[0]), .we(we), .mode(mode), .addr(addr),
    .wdata(wdata), .rdata(rdata_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .err(err_w[0]), .ram_en(ram_en_w[0]), .ram_we(ram_we_w[0]),
    .ram_addr(ram_addr_w[0]), .ram_wdata(ram_wdata_w[0]), .ram_rdata(ram_rdata_w[0])
  );

  mem_access_unit #(.ADDR_W(30), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req_w[1]), .we(we), .mode(mode), .addr(addr),
    .wdata(wdata), .rdata(rdata_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .err(err_w[1]), .ram_en(ram_en_w[1]), .ram_we(ram_we_w[1]),
    .ram_addr(ram_addr_w[1]), .ram_wdata(ram_wdata_w[1]), .ram_rdata(ram_rdata_w[1])
  );

  // RAM models: latency 1 for dut1, 3 for dut3. Non-read cycles shift in a
  // marker word so a mistimed capture is visible.
  logic [31:0] mem0[16], mem1[16];
  logic [31:0] p0;
  logic [31:0] p1[3];
  logic [1:0]  pl_en = 2'b00;
  logic [3:0]  pl_a;
  logic [31:0] pl_d;

  always @(posedge clk) begin
    if (pl_en[0]) mem0[pl_a] <= pl_d;
    else if (ram_en_w[0] && ram_we_w[0]) mem0[ram_addr_w[0][3:0]] <= ram_wdata_w[0];
    p0 <= (ram_en_w[0] && !ram_we_w[0]) ? mem0[ram_addr_w[0][3:0]] : 32'hBAD0BAD0;
    if (pl_en[1]) mem1[pl_a] <= pl_d;
    else if (ram_en_w[1] && ram_we_w[1]) mem1[ram_addr_w[1][3:0]] <= ram_wdata_w[1];
    p1[0] <= (ram_en_w[1] && !ram_we_w[1]) ? mem1[ram_addr_w[1][3:0]] : 32'hBAD0BAD0;
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign ram_rdata_w[0] = p0;
  assign ram_rdata_w[1] = p1[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every RAM access and every done pulse must match the head of
  // the corresponding expectation queue.
  acc_exp_t  ma;
  done_exp_t md;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_en_w[d]) begin
        if (aq[d].size() == 0) begin
          total++; bad++;
          $display("FAIL dut%0d unexpected_ram_access: got we=%0d addr=%h at cyc %0d expected none",
                   d, ram_we_w[d], ram_addr_w[d], cyc);
        end else begin
          ma = aq[d].pop_front();
          chk($sformatf("dut%0d acc_cyc", d), 32'(cyc), 32'(ma.cyc));
          chk($sformatf("dut%0d acc_we", d), 32'(ram_we_w[d]), 32'(ma.we));
          chk($sformatf("dut%0d acc_addr", d), 32'(ram_addr_w[d]), 32'(ma.a));
          if (ma.we) chk($sformatf("dut%0d acc_wdata", d), ram_wdata_w[d], ma.d);
        end
      end
      if (done_w[d]) begin
        if (dq[d].size() == 0) begin
          total++; bad++;
          $display("FAIL dut%0d unexpected_done: got done at cyc %0d expected none", d, cyc);
        end else begin
          md = dq[d].pop_front();
          chk($sformatf("dut%0d done_cyc", d), 32'(cyc), 32'(md.cyc));
          chk($sformatf("dut%0d rdata", d), rdata_w[d], md.rdata);
          chk($sformatf("dut%0d err", d), 32'(err_w[d]), 32'(md.err));
        end
      end
    end
  end

  task automatic preload(input int d, input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_a = a; pl_d = v; pl_en[d] = 1'b1;
    @(negedge clk);
    pl_en[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while (busy_w[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy_w[d]) begin
      total++; bad++;
      $display("FAIL dut%0d idle_timeout: got busy=1 expected busy=0", d);
    end
  endtask

  // One access with hand-computed expected rdata/err and (byte store) merged word.
  task automatic op(input int d, input logic w, input logic [1:0] m, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                    input logic [31:0] exp_wr);
    int t, lat;
    done_exp_t de;
    lat = (d == 0) ? 1 : 3;
    wait_idle(d);
    we = w; mode = m; addr = a; wdata = wd; req_w[d] = 1'b1;
    t = cyc;
    de.rdata = exp_rd;
    de.err   = exp_err;
    if (exp_err) begin
      de.cyc = t + 1;
    end else if (w && m == 2'b00) begin
      aq[d].push_back('{t + 1, 1'b1, a[31:2], wd});
      de.cyc = t + 2;
    end else begin
      aq[d].push_back('{t + 1, 1'b0, a[31:2], 32'd0});
      if (w) begin
        aq[d].push_back('{t + 2 + lat, 1'b1, a[31:2], exp_wr});
        de.cyc = t + 3 + lat;
      end else begin
        de.cyc = t + 2 + lat;
      end
    end
    dq[d].push_back(de);
    @(negedge clk);
    req_w[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n;
    reset = 1'b0; req_w[0] = 1'b0; req_w[1] = 1'b0;
    we = 1'b0; mode = 2'b00; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst rdata", rdata_w[0], 32'h0);
    chk("rst busy", 32'(busy_w[0]), 32'h0);
    chk("rst done", 32'(done_w[0]), 32'h0);
    chk("rst ram_en", 32'(ram_en_w[0]), 32'h0);
    chk("rst ram_addr", 32'(ram_addr_w[1]), 32'h0);
    chk("rst ram_wdata", ram_wdata_w[1], 32'h0);
    reset = 1'b1;

    // ---- WAIT_CYCLES=1 ----
    preload(0, 4'd4, 32'h7F81_0203);
    op(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'h7F810203, 1'b0, 32'h0);
    op(0, 1'b0, 2'b01, 32'h12, 32'h0, 32'hFFFFFF81, 1'b0, 32'h0);
    op(0, 1'b0, 2'b10, 32'h12, 32'h0, 32'h00000081, 1'b0, 32'h0);
    op(0, 1'b0, 2'b01, 32'h13, 32'h0, 32'h0000007F, 1'b0, 32'h0);
    op(0, 1'b0, 2'b10, 32'h10, 32'h0, 32'h00000003, 1'b0, 32'h0);
    wait_idle(0);
    preload(0, 4'd4, 32'h1122_3344);
    op(0, 1'b1, 2'b01, 32'h11, 32'hDEADBEEF, 32'h00000003, 1'b0, 32'h1122EF44);
    op(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'h1122EF44, 1'b0, 32'h0);
    op(0, 1'b1, 2'b00, 32'h14, 32'hCAFEF00D, 32'h1122EF44, 1'b0, 32'h0);
    op(0, 1'b0, 2'b00, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0, 32'h0);
    op(0, 1'b0, 2'b00, 32'h12, 32'h0, 32'hCAFEF00D, 1'b1, 32'h0);
    op(0, 1'b0, 2'b11, 32'h10, 32'h0, 32'hCAFEF00D, 1'b1, 32'h0);
    op(0, 1'b1, 2'b00, 32'h16, 32'h12345678, 32'hCAFEF00D, 1'b1, 32'h0);
    op(0, 1'b1, 2'b10, 32'h17, 32'h000000AB, 32'hCAFEF00D, 1'b0, 32'hABFEF00D);
    op(0, 1'b0, 2'b01, 32'h17, 32'h0, 32'hFFFFFFAB, 1'b0, 32'h0);

    // ---- WAIT_CYCLES=3: back-to-back word loads with req held ----
    preload(1, 4'd4, 32'h0123_4567);
    preload(1, 4'd6, 32'h89AB_CDEF);
    preload(1, 4'd7, 32'h5566_7788);
    wait_idle(1);
    we = 1'b0; mode = 2'b00; addr = 32'h10; req_w[1] = 1'b1;
    t = cyc;
    aq[1].push_back('{t + 1, 1'b0, 30'd4, 32'd0});
    dq[1].push_back('{t + 5, 32'h01234567, 1'b0});
    aq[1].push_back('{t + 7, 1'b0, 30'd6, 32'd0});
    dq[1].push_back('{t + 11, 32'h89ABCDEF, 1'b0});
    @(negedge clk);
    addr = 32'h18;
    while (cyc <= t + 11) begin
      chk($sformatf("b2b busy@T+%0d", cyc - t), 32'(busy_w[1]), 32'(cyc != t + 6));
      if (cyc == t + 7) req_w[1] = 1'b0;
      @(negedge clk);
    end
    req_w[1] = 1'b0;

    // ---- reset during RD_WAIT of a byte store ----
    wait_idle(1);
    we = 1'b1; mode = 2'b01; addr = 32'h1C; wdata = 32'h00000099; req_w[1] = 1'b1;
    t = cyc;
    aq[1].push_back('{t + 1, 1'b0, 30'd7, 32'd0});
    @(negedge clk);
    req_w[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstrw rdata", rdata_w[1], 32'h0);
    chk("rstrw busy", 32'(busy_w[1]), 32'h0);
    chk("rstrw done", 32'(done_w[1]), 32'h0);
    chk("rstrw err", 32'(err_w[1]), 32'h0);
    chk("rstrw ram_en", 32'(ram_en_w[1]), 32'h0);
    chk("rstrw ram_we", 32'(ram_we_w[1]), 32'h0);
    chk("rstrw ram_addr", 32'(ram_addr_w[1]), 32'h0);
    chk("rstrw ram_wdata", ram_wdata_w[1], 32'h0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("rstrw ram_word", mem1[7], 32'h55667788);
    op(1, 1'b0, 2'b00, 32'h1C, 32'h0, 32'h55667788, 1'b0, 32'h0);

    n = 0;
    while ((aq[0].size() + aq[1].size() + dq[0].size() + dq[1].size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d pending_acc", d), 32'(aq[d].size()), 32'd0);
      chk($sformatf("dut%0d pending_done", d), 32'(dq[d].size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle memory access unit between the MIPS controller/datapath and a word-wide synchronous RAM without byte enables. It executes one load or store per request: word (`lw`/`sw`), signed byte (`lb`), unsigned byte (`lbu`) and byte store (`sb`). Byte stores use a read-modify-write sequence. The unit reports completion with a `done` pulse and will later drive the controller's stall input.

## Interface
- `ADDR_W`, default 30: RAM word-address width. `ram_addr` carries `addr[ADDR_W+1:2]`.
- `WAIT_CYCLES`, default 1, must be ≥1: RAM read latency. `ram_rdata` is valid exactly `WAIT_CYCLES` cycles after the read-enable cycle.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  1  request. Sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load (the controller's MemWrite).
- `mode`  in  2  access mode: 00 word, 01 signed byte, 10 unsigned byte, 11 reserved (the controller's MemMode). Byte store uses 01 or 10.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data. Byte store uses `wdata[7:0]`.
- `rdata`  out  32  extended load result.
- `busy`  out  1  an access is in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid only with `done`. Set for a misaligned word access or `mode`=11.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write.
- `ram_addr`  out  ADDR_W  RAM word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data.

## Operation
- Byte lanes are little-endian: `addr[1:0]`=i selects `[8i+7:8i]`.
- State machine states: IDLE, RD, RD_WAIT, WR, DONE, ERR.
- IDLE, with `req`=1: latch `we`, `mode`, `addr`, `wdata`, then branch:
  - `mode`=11, or a word access with `addr[1:0]`≠0 → ERR.
  - word store → WR.
  - otherwise → RD.
- IDLE, with `req`=0: remain in IDLE.
- RD: `ram_en`=1, `ram_we`=0. Load the wait counter with `WAIT_CYCLES`. → RD_WAIT.
- RD_WAIT: decrement the counter. On the cycle data is valid, capture `ram_rdata` and branch:
  - load → compute the result (below), → DONE.
  - byte store → merged word = captured word with the lane replaced by `wdata[7:0]`, → WR.
- Load result by mode:
  - word: the captured word, unchanged.
  - signed byte: the selected byte sign-extended to 32 bits.
  - unsigned byte: the selected byte zero-extended to 32 bits.
- WR: `ram_en`=1, `ram_we`=1. `ram_wdata` = `wdata` for a word store, the merged word for a byte store. → DONE.
- DONE: `done`=1, `err`=0. → IDLE.
- ERR: `done`=1, `err`=1. No RAM access. → IDLE.
- `rdata` updates only when a load completes. It holds through stores, errors and idle periods.
- `busy`=1 in every state except IDLE. `req` is ignored while `busy`=1, including the DONE/ERR cycle.
- A reset sampled low returns the unit to IDLE from any state. In-flight read data is discarded. A write not yet issued is never issued.

## Timing
- Request sampled in IDLE at cycle T.
- Word load: `ram_en` read at T+1. `done` at T+2+`WAIT_CYCLES`.
- Byte load: same timing as a word load.
- Word store: RAM write at T+1. `done` at T+2.
- Byte store: read at T+1, write at T+2+`WAIT_CYCLES`, `done` at T+3+`WAIT_CYCLES`.
- Error: `done`+`err` at T+1.
- Back-to-back: with `req` held high, the next access is sampled in the IDLE cycle after `done`.
- All outputs are registered or decoded from the state register. There is no combinational path from `req`/`addr` to any output.
- Reset value of every output is 0: `rdata`, `busy`, `done`, `err`, `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`.

## Structure
- Shared package `mips_mem_pkg` holds:
  - MemMode encodings (`MODE_WORD`, `MODE_SBYTE`, `MODE_UBYTE`), shared with the controller.
  - The state encoding.
- Combinational sub-module `byte_lane_unit` performs lane extraction, sign/zero extension and store merge.
- The top level holds the state machine, request latches and wait counter.

## Test plan
- Word load (`WAIT_CYCLES`=1): RAM[word 4]=0x7F81_0203; `req`, `mode`=00, `addr`=0x10 → read of `ram_addr`=4 at T+1; `done` at T+3; `rdata`=0x7F810203; `err`=0.
- Byte loads from the same word:
  - `lb` 0x12 → `rdata`=0xFFFFFF81.
  - `lbu` 0x12 → 0x00000081.
  - `lb` 0x13 → 0x0000007F.
- Byte store: RAM[4]=0x11223344; `we`=1, `mode`=01, `addr`=0x11, `wdata`=0xDEADBEEF → write 0x1122EF44 at T+3; `done` at T+4; `rdata` unchanged.
- Errors:
  - word load at 0x12 → `done`+`err` at T+1, `ram_en` never asserted.
  - `mode`=11 at 0x10 → same response.
- Reset during RD_WAIT of a byte store (`WAIT_CYCLES`=3) → next cycle all outputs 0; RAM word unmodified; a following word load completes normally.
- `req` held high, `WAIT_CYCLES`=3, two word loads → `done` at T+5 and T+11; `busy` low only in T+6 (IDLE) between them.
